// File: rtl/cond_pkg.sv
// cond_pkg: shared condition codes, NZCV flag struct and field width for the condition evaluator (no ports).
package cond_pkg;
  localparam int COND_W = 4;
  typedef enum logic [COND_W-1:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;
endpackage

// File: rtl/cond_lane_eval.sv
// cond_lane_eval: combinational single-lane ARM condition check; ports cond (4-bit code), f (NZCV) -> pass.
module cond_lane_eval
  import cond_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  flags_t            f,
  output logic              pass
);
  logic base;
  always_comb begin
    case (cond[3:1])
      3'd0:    base = f.z;
      3'd1:    base = f.c;
      3'd2:    base = f.n;
      3'd3:    base = f.v;
      3'd4:    base = f.c & ~f.z;
      3'd5:    base = f.n ~^ f.v;
      3'd6:    base = ~f.z & (f.n ~^ f.v);
      default: base = 1'b1;
    endcase
    pass = base ^ cond[0];
  end
endmodule

// File: rtl/cond_eval_unit.sv
// cond_eval_unit: multi-lane condition evaluator with NZCV register, flag-writer hazard stall and registered per-lane pass bits; clk/rst, flush, flag_issue/flag_we/flag_in/flag_mask, in_valid/in_cond/in_ready, out_valid/out_pass/out_ready, sr_out, pend_full, err_underflow; COND_BYPASS_EN forwards writeback flags into evaluation.
module cond_eval_unit
  import cond_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int MAX_PENDING = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    flag_issue,
  output logic                    pend_full,
  input  logic                    flag_we,
  input  logic [3:0]              flag_in,
  input  logic [3:0]              flag_mask,
  input  logic [LANES-1:0]        in_valid,
  input  logic [COND_W*LANES-1:0] in_cond,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [LANES-1:0]        out_pass,
  input  logic                    out_ready,
  output logic [3:0]              sr_out,
  output logic                    err_underflow
);
  localparam int PW = $clog2(MAX_PENDING + 1);
  flags_t          sr, sr_nx, f;
  logic [PW-1:0]   pending, pend_nx, p;
  logic [LANES-1:0] pass, heavy;
  logic            stall, accept, retire;
  assign retire = flag_we && pending != '0;
  assign sr_nx  = flag_we ? flags_t'((flag_mask & flag_in) | (~flag_mask & sr)) : sr;
`ifdef COND_BYPASS_EN
  assign f = sr_nx;
  assign p = pending - PW'(retire);
`else
  assign f = sr;
  assign p = pending;
`endif
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cond_lane_eval u_eval (.cond(in_cond[COND_W*i +: COND_W]), .f(f), .pass(pass[i]));
    assign heavy[i] = in_valid[i] && in_cond[COND_W*i +: COND_W] < COND_W'(AL);
  end
  assign pend_full = pending == PW'(MAX_PENDING);
  assign stall     = p != '0 && |heavy;
  assign in_ready  = !stall && (!out_valid || out_ready) && !flush;
  assign accept    = |in_valid && in_ready;
  assign sr_out    = sr;
  always_comb
    pend_nx = flush ? PW'(flag_issue)
            : (flag_issue && !flag_we && !pend_full) ? pending + 1'b1
            : (flag_we && !flag_issue && retire) ? pending - 1'b1
            : pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr            <= '0;
      pending       <= '0;
      out_valid     <= 1'b0;
      out_pass      <= '0;
      err_underflow <= 1'b0;
    end else begin
      sr            <= sr_nx;
      pending       <= pend_nx;
      err_underflow <= err_underflow | (flag_we && pending == '0);
      if (flush) begin
        out_valid <= 1'b0;
        out_pass  <= '0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_pass  <= in_valid & pass;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cond_eval_unit.sv
// tb_cond_eval_unit: directed test-plan sequence plus randomized traffic checked against a behavioural model.
module tb_cond_eval_unit;
  localparam int MAXP = 3;
  logic       clk = 0, rst, flush, flag_issue, flag_we, out_ready;
  logic [3:0] flag_in, flag_mask, sr_out;
  logic [1:0] in_valid, out_pass;
  logic [7:0] in_cond;
  logic       pend_full, in_ready, out_valid, err_underflow;
  int         checks = 0, failures = 0;
  logic [3:0] m_sr;
  int         m_pend;
  bit         m_ov, m_err;
  logic [1:0] m_op;
  cond_eval_unit #(.LANES(2), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flag_issue(flag_issue), .pend_full(pend_full),
    .flag_we(flag_we), .flag_in(flag_in), .flag_mask(flag_mask), .in_valid(in_valid),
    .in_cond(in_cond), .in_ready(in_ready), .out_valid(out_valid), .out_pass(out_pass),
    .out_ready(out_ready), .sr_out(sr_out), .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit eval(input int code, input logic [3:0] fl);
    bit n = fl[3], z = fl[2], c = fl[1], v = fl[0];
    case (code)
      0: return z;             1: return !z;
      2: return c;             3: return !c;
      4: return n;             5: return !n;
      6: return v;             7: return !v;
      8: return c && !z;       9: return !c || z;
      10: return n == v;       11: return n != v;
      12: return !z && n == v; 13: return z || n != v;
      14: return 1;            default: return 0;
    endcase
  endfunction
  task automatic cyc(input bit r, fi, fw, input logic [3:0] fin, fm, input logic [1:0] iv,
                     input logic [7:0] ic, input bit fl, ordy);
    logic [3:0] srn, fe;
    int p;
    bit stall, rdy;
    rst = r; flag_issue = fi; flag_we = fw; flag_in = fin; flag_mask = fm;
    in_valid = iv; in_cond = ic; flush = fl; out_ready = ordy;
    srn = fw ? ((fm & fin) | (~fm & m_sr)) : m_sr;
`ifdef COND_BYPASS_EN
    fe = srn;
    p = (fw && m_pend > 0) ? m_pend - 1 : m_pend;
`else
    fe = m_sr;
    p = m_pend;
`endif
    stall = 0;
    for (int l = 0; l < 2; l++) if (iv[l] && ic[4*l +: 4] < 14 && p != 0) stall = 1;
    rdy = !stall && (!m_ov || ordy) && !fl;
    #1;
    chk("in_ready", in_ready, rdy);
    chk("pend_full", pend_full, m_pend == MAXP);
    chk("sr_out", sr_out, m_sr);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("out_pass", out_pass, m_op);
    chk("err_underflow", err_underflow, m_err);
    @(posedge clk); #1;
    if (r) begin
      m_sr = 0; m_pend = 0; m_ov = 0; m_op = 0; m_err = 0;
    end else begin
      m_err = m_err || (fw && m_pend == 0);
      if (fl) begin
        m_pend = fi ? 1 : 0; m_ov = 0; m_op = 0;
      end else begin
        if (fi && !fw && m_pend < MAXP) m_pend++;
        else if (fw && !fi && m_pend > 0) m_pend--;
        if (iv != 0 && rdy) begin
          m_ov = 1;
          for (int l = 0; l < 2; l++) m_op[l] = iv[l] && eval(int'(ic[4*l +: 4]), fe);
        end else if (ordy) m_ov = 0;
      end
      m_sr = srn;
    end
  endtask
  task automatic idle(input bit fi, fw, input logic [3:0] fin, fm);
    cyc(0, fi, fw, fin, fm, 2'b00, 8'h00, 0, 1);
  endtask
  task automatic grp(input logic [7:0] ic, input bit ordy);
    cyc(0, 0, 0, 4'h0, 4'h0, 2'b11, ic, 0, ordy);
  endtask
  initial begin
    rst = 1; flush = 0; flag_issue = 0; flag_we = 0; flag_in = 0; flag_mask = 0;
    in_valid = 0; in_cond = 0; out_ready = 1;
    @(posedge clk); #1;
    m_sr = 0; m_pend = 0; m_ov = 0; m_op = 0; m_err = 0;
    cyc(1, 0, 0, 4'h0, 4'h0, 2'b00, 8'h00, 0, 1);
    chk("rst_sr", sr_out, 4'h0);
    chk("rst_ov", out_valid, 0);
    chk("rst_op", out_pass, 2'b00);
    chk("rst_rdy", in_ready, 1);
    chk("rst_full", pend_full, 0);
    chk("rst_err", err_underflow, 0);
    grp(8'h10, 1);
    chk("eq_ne", out_pass, 2'b10);
    idle(1, 0, 4'h0, 4'h0);
    grp(8'hEC, 1);
    chk("stall_rdy", in_ready, 0);
    grp(8'hEC, 1);
    cyc(0, 0, 1, 4'h0, 4'hF, 2'b11, 8'hEC, 0, 1);
`ifndef COND_BYPASS_EN
    chk("wb_no_acc", out_valid, 0);
    grp(8'hEC, 1);
`endif
    chk("gt_al_v", out_valid, 1);
    chk("gt_al", out_pass, 2'b11);
    idle(1, 0, 4'h0, 4'h0);
    idle(0, 1, 4'b0101, 4'hF);
    grp(8'hCD, 1); chk("gt_le", out_pass, 2'b01);
    grp(8'hAF, 1); chk("ge_nv", out_pass, 2'b00);
    grp(8'hED, 1); chk("al_le", out_pass, 2'b11);
    repeat (3) idle(1, 0, 4'h0, 4'h0);
    chk("full3", pend_full, 1);
    idle(1, 1, 4'h0, 4'h0);
    chk("full_both", pend_full, 1);
    repeat (3) idle(0, 1, 4'h0, 4'h0);
    chk("err_pre", err_underflow, 0);
    idle(0, 1, 4'h0, 4'h0);
    chk("err_set", err_underflow, 1);
    grp(8'hED, 1);
    grp(8'hED, 0);
    chk("hold_v", out_valid, 1);
    chk("hold_p", out_pass, 2'b11);
    cyc(0, 0, 0, 4'h0, 4'h0, 2'b11, 8'hED, 1, 0);
    chk("flush_v", out_valid, 0);
    chk("flush_sr", sr_out, 4'b0101);
    idle(1, 0, 4'h0, 4'h0);
    idle(0, 1, 4'h0, 4'hF);
    idle(1, 0, 4'h0, 4'h0);
    idle(0, 1, 4'hF, 4'hC);
    chk("mask", sr_out, 4'b1100);
    for (int k = 0; k < 3000; k++) begin
      bit r, fi, fw, fl, ordy;
      logic [7:0] ic;
      r  = $urandom_range(99) == 0;
      fi = m_pend < MAXP && $urandom_range(2) == 0;
      fw = m_pend > 0 ? $urandom_range(2) == 0 : $urandom_range(19) == 0;
      fl = $urandom_range(29) == 0;
      ordy = $urandom_range(3) != 0;
      for (int l = 0; l < 2; l++)
        ic[4*l +: 4] = $urandom_range(3) == 0 ? 4'(14 + $urandom_range(1)) : 4'($urandom_range(15));
      cyc(r, fi, fw, 4'($urandom), 4'($urandom), 2'($urandom), ic, fl, ordy);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
